mac_sched: RTL and testbench
============================

MAC_SCHED -- requirements
Module: mac_sched

Interface
REQ-001 The block SHALL use reset rst (asynchronous, active-high) and clock clk.
REQ-002 Port list (name, direction, width, meaning), in order:
  clk         in   1   clock, rising edge
  rst         in   1   async reset, active-high
  req         in   2   per-client request level; held high until that client's done/err
  x0, y0      in   32  client 0 operand vectors: 4 unsigned bytes each, byte i = bits [8i+7:8i]
  x1, y1      in   32  client 1 operand vectors, same layout
  done        out  2   one-hot, 1-cycle pulse: granted client's dot product is complete
  err         out  2   one-hot, 1-cycle pulse: granted client's job aborted on timeout
  result      out  20  last completed dot product; held between jobs
  busy        out  1   high in every state except IDLE
  mult_start  out  1   1-cycle pulse that launches the shared 8x8 multiplier
  mult_a      out  8   multiplier operand A
  mult_b      out  8   multiplier operand B
  mult_done   in   1   1-cycle pulse from the multiplier; mult_p is valid in this cycle
  mult_p      in   16  unsigned 16-bit product

Function
REQ-003 The block SHALL share one external multiplier between two clients and compute result = sum over i=0..3 of x[i]*y[i], unsigned.
REQ-004 The state machine SHALL have exactly these states: IDLE, ISSUE, WAIT, DONE.
REQ-005 IDLE, when req is nonzero:
  - grant one client per REQ-006
  - latch that client's x and y into internal operand registers
  - clear the 20-bit accumulator; set byte index idx=0
  - next state ISSUE
  When req==0, the block SHALL stay in IDLE.
REQ-006 Arbitration SHALL be round-robin on a 1-bit last-served pointer (reset 1, so client 0 wins first).
  - Single request: that client is granted.
  - Both requesting: the client that is not last-served is granted.
REQ-007 req SHALL be sampled only in IDLE. Changes to req or operand inputs outside IDLE SHALL have no effect on the job in progress.
REQ-008 ISSUE (one cycle):
  - mult_start=1
  - mult_a = latched x byte idx; mult_b = latched y byte idx
  - clear the timeout counter; next state WAIT
REQ-009 mult_a and mult_b SHALL hold the ISSUE values throughout WAIT. They SHALL be 0 in IDLE and DONE.
REQ-010 WAIT, on mult_done=1:
  - acc <= acc + {4'b0, mult_p}, modulo 2^20; no overflow is possible (maximum 260100)
  - if idx==3, load result <= final sum and go to DONE
  - otherwise idx <= idx+1 and go to ISSUE
REQ-011 mult_done SHALL be ignored outside WAIT.
REQ-012 WAIT SHALL count cycles in a 6-bit timeout counter. When 63 cycles elapse without mult_done, the block SHALL:
  - pulse err[granted] for one cycle
  - not assert done and leave result unchanged
  - update the last-served pointer
  - return to IDLE
REQ-013 DONE (one cycle): done[granted]=1, last-served pointer <= granted, next state IDLE.
REQ-014 A req still high in the IDLE cycle after DONE SHALL be treated as a new job.
REQ-015 Latency: with mult_done arriving in the cycle after each mult_start, done SHALL assert exactly 9 cycles after the IDLE cycle in which req was sampled.
REQ-016 done and err SHALL never be asserted in the same cycle. At most one bit of each SHALL ever be set.
REQ-017 The block SHALL compute the sum fully; a partial sum SHALL never appear on result.

Reset
REQ-018 While rst=1, outputs SHALL be: done=0, err=0, result=0, busy=0, mult_start=0, mult_a=0, mult_b=0.
REQ-019 While rst=1, internal state SHALL be: state=IDLE, acc=0, idx=0, timeout=0, last-served pointer=1.
REQ-020 Reset asserted mid-job SHALL abort the job immediately, with no done or err pulse. A mult_done arriving after reset release SHALL be ignored.

Verification
REQ-021 Single job: req=01, x0=0x04030201, y0=0x08070605, multiplier returns in 1 cycle.
  -> mult_a sequence 1,2,3,4; done=01 at cycle 9; result=0x00046 (70).
REQ-022 Maximum operands: x1=y1=0xFFFFFFFF, req=10.
  -> done=10; result=0x3F804 (260100); no wrap.
REQ-023 Arbitration fairness: req=11 held continuously after reset, client 1 job 1*1 (x1=y1=0x00000001).
  -> grants alternate 0,1,0,1; each done pulse goes to the matching client.
REQ-024 Slow multiplier: mult_done delayed 10 cycles per product.
  -> correct result; mult_a/mult_b stable during each WAIT; busy high throughout.
REQ-025 Timeout: mult_done never returned after the second mult_start.
  -> err pulses for the granted client exactly 63 cycles into that WAIT; done stays 0; result keeps its previous value; the next job is granted to the other requesting client.
REQ-026 Reset mid-job: rst pulsed during the WAIT of product 2.
  -> all outputs 0 next cycle; a stray mult_done afterwards is ignored; a fresh job then completes correctly.

Source files
------------

// File: rtl/mac_sched.sv
// mac_sched: two-client dot-product scheduler sharing one external 8x8 multiplier.
// Each job computes result = sum x[i]*y[i] over four unsigned bytes.
module mac_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [31:0] x0,
  input  logic [31:0] y0,
  input  logic [31:0] x1,
  input  logic [31:0] y1,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic [19:0] result,
  output logic        busy,
  output logic        mult_start,
  output logic [7:0]  mult_a,
  output logic [7:0]  mult_b,
  input  logic        mult_done,
  input  logic [15:0] mult_p
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_x;
  logic [31:0] r_y;
  logic [19:0] r_acc;
  logic [19:0] r_result;
  logic [1:0]  r_idx;
  logic [5:0]  r_tmo;
  logic        r_gnt;
  logic        r_last;

  logic        w_gnt;
  logic        w_tmo_hit;
  logic [19:0] w_sum;
  logic [7:0]  w_xb;
  logic [7:0]  w_yb;
  logic [1:0]  w_gnt_vec;

  assign w_xb      = r_x[{r_idx, 3'b000} +: 8];
  assign w_yb      = r_y[{r_idx, 3'b000} +: 8];
  assign w_sum     = r_acc + {4'b0000, mult_p};
  assign w_tmo_hit = (r_tmo == 6'd63);
  assign w_gnt_vec = r_gnt ? 2'b10 : 2'b01;
  assign result    = r_result;

  // Round-robin pick: a lone requester wins, on contention the client not served last wins.
  always_comb begin
    w_gnt = 1'b0;
    if (req == 2'b10) begin
      w_gnt = 1'b1;
    end else if (req == 2'b11) begin
      w_gnt = ~r_last;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and output decode; multiplier operands follow the latched byte only in ISSUE/WAIT.
  always_comb begin
    w_next     = r_state;
    done       = '0;
    err        = '0;
    busy       = 1'b1;
    mult_start = 1'b0;
    mult_a     = '0;
    mult_b     = '0;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (req != 2'b00) begin
          w_next = ISSUE;
        end
      end
      ISSUE: begin
        mult_start = 1'b1;
        mult_a     = w_xb;
        mult_b     = w_yb;
        w_next     = WAIT;
      end
      WAIT: begin
        mult_a = w_xb;
        mult_b = w_yb;
        if (mult_done) begin
          w_next = (r_idx == 2'd3) ? DONE : ISSUE;
        end else if (w_tmo_hit) begin
          err    = w_gnt_vec;
          w_next = IDLE;
        end
      end
      DONE: begin
        done   = w_gnt_vec;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Job datapath: grant/operand latch, accumulation, timeout counting and fairness pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_tmo    <= '0;
      r_gnt    <= 1'b0;
      r_last   <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req != 2'b00) begin
            r_gnt <= w_gnt;
            r_x   <= w_gnt ? x1 : x0;
            r_y   <= w_gnt ? y1 : y0;
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        ISSUE: begin
          r_tmo <= '0;
        end
        WAIT: begin
          if (mult_done) begin
            r_acc <= w_sum;
            if (r_idx == 2'd3) begin
              r_result <= w_sum;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end else if (w_tmo_hit) begin
            r_last <= r_gnt;
          end else begin
            r_tmo <= r_tmo + 6'd1;
          end
        end
        DONE: begin
          r_last <= r_gnt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_sched.sv
// tb_mac_sched: scoreboard bench for mac_sched with a behavioural multiplier of settable delay.
module tb_mac_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [31:0] x0, y0, x1, y1;
  logic [1:0]  done, err;
  logic [19:0] result;
  logic        busy, mult_start;
  logic [7:0]  mult_a, mult_b;
  logic        mult_done;
  logic [15:0] mult_p = '0;
  logic        md_model = 1'b0;
  logic        md_stray;

  assign mult_done = md_model | md_stray;

  always #5 clk = ~clk;

  mac_sched dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .x0         (x0),
    .y0         (y0),
    .x1         (x1),
    .y1         (y1),
    .done       (done),
    .err        (err),
    .result     (result),
    .busy       (busy),
    .mult_start (mult_start),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_done  (mult_done),
    .mult_p     (mult_p)
  );

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] dot(input logic [31:0] a, input logic [31:0] b);
    logic [19:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s = s + 20'(a[8*i +: 8]) * 20'(b[8*i +: 8]);
    end
    return s;
  endfunction

  // Multiplier model: captures operands on mult_start, answers mul_delay cycles later;
  // the start numbered drop_at is never answered.
  int unsigned mul_delay = 1;
  int unsigned drop_at   = 0;
  int unsigned starts    = 0;
  int unsigned cnt       = 0;
  logic        pend      = 1'b0;
  logic [15:0] pend_p    = '0;

  always @(posedge clk) begin
    #1;
    md_model = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (cnt <= 1) begin
          md_model = 1'b1;
          mult_p   = pend_p;
          pend     = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (mult_start) begin
        starts++;
        if (starts != drop_at) begin
          pend   = 1'b1;
          cnt    = mul_delay;
          pend_p = 16'(mult_a) * 16'(mult_b);
        end
      end
    end
  end

  // Scoreboard: expected completion events in grant order.
  typedef struct packed {
    logic [1:0]  d;
    logic [1:0]  e;
    logic [19:0] r;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic push(input logic [1:0] d, input logic [1:0] e, input logic [19:0] r);
    exp_q.push_back(exp_t'{d, e, r});
  endtask

  always @(negedge clk) begin
    if (done != 2'b00 || err != 2'b00) begin
      chk("done_err_excl", 32'((done != 2'b00) && (err != 2'b00)), 32'd0);
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", 32'({done, err}), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_done",   32'(done),   32'(mon_e.d));
        chk("sb_err",    32'(err),    32'(mon_e.e));
        chk("sb_result", 32'(result), 32'(mon_e.r));
      end
    end
  end

  logic [7:0]  sa [4];
  logic [7:0]  sb [4];
  int unsigned nst, s2n, unstable, idle_gaps;

  // Step negedges until done or err appears, logging operands and WAIT stability.
  task automatic wait_evt(input int unsigned budget, output int unsigned n);
    logic [7:0] la, lb;
    n = 0; nst = 0; s2n = 0; unstable = 0; idle_gaps = 0; la = '0; lb = '0;
    do begin
      @(negedge clk);
      n++;
      if (mult_start) begin
        if (nst < 4) begin
          sa[nst] = mult_a;
          sb[nst] = mult_b;
        end
        nst++;
        if (nst == 2) s2n = n;
        la = mult_a;
        lb = mult_b;
      end else if (busy && done == 2'b00 && (mult_a != la || mult_b != lb)) begin
        unstable++;
      end
      if (!busy) idle_gaps++;
    end while (done == 2'b00 && err == 2'b00 && n < budget);
    if (done == 2'b00 && err == 2'b00) chk("evt_timeout", 32'({done, err}), 32'd1);
  endtask

  task automatic check_zero(input string p);
    chk({p, "_done"},   32'(done),       32'd0);
    chk({p, "_err"},    32'(err),        32'd0);
    chk({p, "_result"}, 32'(result),     32'd0);
    chk({p, "_busy"},   32'(busy),       32'd0);
    chk({p, "_start"},  32'(mult_start), 32'd0);
    chk({p, "_a"},      32'(mult_a),     32'd0);
    chk({p, "_b"},      32'(mult_b),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    int unsigned k;
    int unsigned sc;
    logic [19:0] prev;

    rst = 1'b1; req = 2'b00; md_stray = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst = 1'b0;
    @(negedge clk);

    // Single job, client 0.
    x0 = 32'h04030201; y0 = 32'h08070605;
    push(2'b01, 2'b00, 20'd70);
    req = 2'b01;
    wait_evt(20, n);
    req = 2'b00;
    chk("t1_latency", n, 32'd9);
    chk("t1_starts", nst, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_mult_a", 32'(sa[i]), 32'(i + 1));
      chk("t1_mult_b", 32'(sb[i]), 32'(i + 5));
    end
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_a", 32'(mult_a), 32'd0);
    chk("t1_result_held", 32'(result), 32'd70);

    // Fairness from reset with both clients requesting continuously.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    x0 = 32'h01020304; y0 = 32'h01010101; x1 = 32'h1; y1 = 32'h1;
    push(2'b01, 2'b00, 20'd10);
    push(2'b10, 2'b00, 20'd1);
    push(2'b01, 2'b00, 20'd10);
    push(2'b10, 2'b00, 20'd1);
    req = 2'b11;
    repeat (4) wait_evt(30, n);
    req = 2'b00;
    @(negedge clk);

    // Maximum operands, client 1.
    x1 = 32'hFFFFFFFF; y1 = 32'hFFFFFFFF;
    push(2'b10, 2'b00, 20'd260100);
    req = 2'b10;
    wait_evt(20, n);
    req = 2'b00;
    chk("t3_latency", n, 32'd9);
    @(negedge clk);

    // Slow multiplier.
    mul_delay = 10;
    x0 = 32'h0A141E28; y0 = 32'h03050709;
    prev = dot(x0, y0);
    push(2'b01, 2'b00, prev);
    req = 2'b01;
    wait_evt(200, n);
    req = 2'b00;
    chk("t5_starts", nst, 32'd4);
    chk("t5_unstable", unstable, 32'd0);
    chk("t5_busy_gaps", idle_gaps, 32'd0);
    mul_delay = 1;
    @(negedge clk);

    // Timeout on the second product, then the other client is served.
    x0 = 32'h11223344; y0 = 32'h02020202; x1 = 32'h1; y1 = 32'h1;
    drop_at = starts + 2;
    push(2'b00, 2'b10, prev);
    push(2'b01, 2'b00, dot(x0, y0));
    req = 2'b11;
    wait_evt(200, n);
    drop_at = 0;
    chk("t6_tmo_cycles", n - s2n, 32'd64);
    chk("t6_err", 32'(err), 32'h2);
    wait_evt(30, n);
    req = 2'b00;
    chk("t6_next_latency", n, 32'd10);
    @(negedge clk);

    // Reset during the WAIT of product 2, then a stray mult_done, then a fresh job.
    mul_delay = 5;
    x0 = 32'h05050505; y0 = 32'h06060606;
    req = 2'b01;
    k = 0; sc = 0;
    while (sc < 2 && k < 50) begin
      @(negedge clk);
      k++;
      if (mult_start) sc++;
    end
    chk("t7_reach_p2", sc, 32'd2);
    @(negedge clk);
    chk("t7_in_wait", 32'({busy, mult_start}), 32'h2);
    rst = 1'b1; req = 2'b00;
    @(negedge clk);
    check_zero("t7");
    rst = 1'b0;
    @(negedge clk);
    md_stray = 1'b1;
    @(negedge clk);
    md_stray = 1'b0;
    chk("t7_stray_busy", 32'(busy), 32'd0);
    chk("t7_stray_result", 32'(result), 32'd0);
    @(negedge clk);
    mul_delay = 1;
    x0 = 32'hFF000102; y0 = 32'h01FF0304;
    push(2'b01, 2'b00, 20'd266);
    req = 2'b01;
    wait_evt(20, n);
    req = 2'b00;
    chk("t7_latency", n, 32'd9);
    @(negedge clk);
    @(negedge clk);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
